// File: rtl/mem_arb_if.sv
// Signal bundle between the fetch/LSU requesters, the arbiter and the memory bus.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface mem_arb_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              if_err;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [2:0]        ls_size;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic              ls_err;
    logic [31:0]       ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_err, if_rdata,
               ls_gnt, ls_rvalid, ls_err, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_err, if_rdata,
               ls_gnt, ls_rvalid, ls_err, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester (fetch / load-store) arbiter onto a single memory bus with
// one outstanding transaction, misalignment errors and a response timeout.
//
// state | meaning
// IDLE  | no transaction; accept one requester, alternating on contention
// REQ   | bus request driven from captured registers, waiting for mem_gnt
// WAIT  | bus accepted, waiting for mem_rvalid
// ERR   | misaligned/invalid LS access, one-cycle error response
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

    localparam logic [7:0]        TMO_LIM   = 8'(TMO_CYC);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_t            state;
    state_t            state_nxt;
    logic              last_ls;
    logic              own_ls;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic       pick_ls;
    logic       accept;
    logic       ls_bad;
    logic [3:0] be_ls;
    logic       tmo;
    logic       rsp;

    // On contention the side that was not served last wins.
    assign pick_ls = bus.ls_req && (!bus.if_req || !last_ls);
    assign accept  = (state == IDLE) && (bus.if_req || bus.ls_req);
    assign tmo     = ((state == REQ) || (state == WAIT)) && (cnt == TMO_LIM);
    assign rsp     = (state == WAIT) && bus.mem_rvalid;

    always_comb begin
        be_ls  = 4'b0000;
        ls_bad = 1'b0;
        case (bus.ls_size)
            3'b001:  be_ls = 4'b0001 << bus.ls_addr[1:0];
            3'b010: begin
                be_ls  = 4'b0011 << {bus.ls_addr[1], 1'b0};
                ls_bad = bus.ls_addr[0];
            end
            3'b100: begin
                be_ls  = 4'b1111;
                ls_bad = |bus.ls_addr[1:0];
            end
            default: ls_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (pick_ls && ls_bad) ? ERR : REQ;
            end
            REQ: begin
                if (tmo)              state_nxt = IDLE;
                else if (bus.mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (rsp || tmo) state_nxt = IDLE;
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls <= 1'b0;
            own_ls  <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            own_ls  <= pick_ls;
            last_ls <= pick_ls;
            cnt     <= '0;
            if (pick_ls) begin
                addr_q  <= bus.ls_addr & ADDR_MASK;
                we_q    <= bus.ls_we;
                wdata_q <= bus.ls_wdata;
                be_q    <= be_ls;
            end else begin
                addr_q  <= bus.if_addr & ADDR_MASK;
                we_q    <= 1'b0;
                wdata_q <= '0;
                be_q    <= 4'b1111;
            end
        end else if ((state == REQ) || (state == WAIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Grants are combinational; gating with rst_n keeps them low during reset.
    assign bus.if_gnt    = rst_n && accept && !pick_ls;
    assign bus.ls_gnt    = rst_n && accept && pick_ls;

    assign bus.if_rvalid = (rsp || tmo) && !own_ls;
    assign bus.ls_rvalid = ((rsp || tmo) && own_ls) || (state == ERR);
    assign bus.if_err    = tmo && !rsp && !own_ls;
    assign bus.ls_err    = (tmo && !rsp && own_ls) || (state == ERR);
    assign bus.if_rdata  = (rsp && !own_ls) ? bus.mem_rdata : '0;
    assign bus.ls_rdata  = (rsp && own_ls) ? bus.mem_rdata : '0;

    assign bus.mem_req   = (state == REQ) && !tmo;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, byte enables and timing.
module tb_mem_arb;
    localparam int AW  = 32;
    localparam int TMO = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   last_ls  = 1'b0;

    mem_arb_if #(.ADDR_W(AW)) bus ();

    mem_arb #(.ADDR_W(AW), .TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.ls_req     = 1'b0;
        bus.ls_we      = 1'b0;
        bus.ls_addr    = '0;
        bus.ls_wdata   = '0;
        bus.ls_size    = 3'b000;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic scramble();
        bus.if_req   = 1'($urandom_range(0, 1));
        bus.ls_req   = 1'($urandom_range(0, 1));
        bus.if_addr  = $urandom;
        bus.ls_addr  = $urandom;
        bus.ls_we    = 1'($urandom_range(0, 1));
        bus.ls_wdata = $urandom;
        bus.ls_size  = 3'($urandom_range(0, 7));
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk_rsp(input bit to_ls, input bit is_err, input logic [31:0] data);
        chk("if_rvalid", bus.if_rvalid, !to_ls);
        chk("ls_rvalid", bus.ls_rvalid, to_ls);
        chk("if_err", bus.if_err, !to_ls && is_err);
        chk("ls_err", bus.ls_err, to_ls && is_err);
        if (to_ls) chk("ls_rdata", bus.ls_rdata, data);
        else       chk("if_rdata", bus.if_rdata, data);
    endtask

    // Starts between edges with the DUT idle; returns between edges, DUT idle again.
    // gnt_dly / rsp_dly < 0 mean the bus never grants / never responds.
    task automatic run_txn(input bit ifr, input bit lsr, input logic [31:0] ia,
                           input logic [31:0] la, input bit lwe, input logic [31:0] lwd,
                           input logic [2:0] lsz, input int gnt_dly, input int rsp_dly,
                           input logic [31:0] rd);
        bit          win_ls, bad, done, in_wait, rv;
        int          nb, t, k;
        logic [31:0] exp_addr, exp_wd;
        logic [3:0]  exp_be;
        bit          exp_we;

        bus.if_req = ifr; bus.ls_req = lsr; bus.if_addr = ia; bus.ls_addr = la;
        bus.ls_we = lwe; bus.ls_wdata = lwd; bus.ls_size = lsz;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        if (!ifr && !lsr) begin
            chk("idle_if_gnt", bus.if_gnt, 1'b0);
            chk("idle_ls_gnt", bus.ls_gnt, 1'b0);
            @(negedge clk);
            return;
        end
        win_ls = lsr && (!ifr || !last_ls);
        chk("ls_gnt", bus.ls_gnt, win_ls);
        chk("if_gnt", bus.if_gnt, !win_ls);
        nb = nbytes(lsz);
        if (win_ls) begin
            bad      = (nb == 0) ? 1'b1 : ((la % nb) != 0);
            exp_addr = la - (la % 4);
            exp_be   = (nb == 0) ? 4'b0000 : 4'(((1 << nb) - 1) << (la % 4));
            exp_we   = lwe;
            exp_wd   = lwd;
        end else begin
            bad      = 1'b0;
            exp_addr = ia - (ia % 4);
            exp_be   = 4'b1111;
            exp_we   = 1'b0;
            exp_wd   = '0;
        end
        last_ls = win_ls;
        @(negedge clk);

        if (bad) begin
            scramble();
            #1;
            chk("err_mem_req", bus.mem_req, 1'b0);
            chk("err_if_gnt", bus.if_gnt, 1'b0);
            chk("err_ls_gnt", bus.ls_gnt, 1'b0);
            chk_rsp(1'b1, 1'b1, 32'h0);
            @(negedge clk);
        end else begin
            t = 0; k = 0; done = 1'b0; in_wait = 1'b0;
            while (!done && t <= TMO + 2) begin
                scramble();
                if (!in_wait) begin
                    bus.mem_gnt    = (t == gnt_dly);
                    bus.mem_rvalid = 1'($urandom_range(0, 1));
                    bus.mem_rdata  = $urandom;
                    #1;
                    chk("busy_if_gnt", bus.if_gnt, 1'b0);
                    chk("busy_ls_gnt", bus.ls_gnt, 1'b0);
                    if (t == TMO) begin
                        chk("tmo_mem_req", bus.mem_req, 1'b0);
                        chk_rsp(win_ls, 1'b1, 32'h0);
                        done = 1'b1;
                    end else begin
                        chk("mem_req", bus.mem_req, 1'b1);
                        chk("mem_addr", bus.mem_addr, exp_addr);
                        chk("mem_be", bus.mem_be, exp_be);
                        chk("mem_we", bus.mem_we, exp_we);
                        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wd);
                        chk("req_if_rvalid", bus.if_rvalid, 1'b0);
                        chk("req_ls_rvalid", bus.ls_rvalid, 1'b0);
                        if (t == gnt_dly) begin in_wait = 1'b1; k = 0; end
                    end
                end else begin
                    rv             = (k == rsp_dly);
                    bus.mem_gnt    = 1'($urandom_range(0, 1));
                    bus.mem_rvalid = rv;
                    bus.mem_rdata  = rv ? rd : $urandom;
                    #1;
                    chk("busy_if_gnt", bus.if_gnt, 1'b0);
                    chk("busy_ls_gnt", bus.ls_gnt, 1'b0);
                    chk("wait_mem_req", bus.mem_req, 1'b0);
                    if (rv) begin
                        chk_rsp(win_ls, 1'b0, rd);
                        done = 1'b1;
                    end else if (t == TMO) begin
                        chk_rsp(win_ls, 1'b1, 32'h0);
                        done = 1'b1;
                    end else begin
                        chk("wait_if_rvalid", bus.if_rvalid, 1'b0);
                        chk("wait_ls_rvalid", bus.ls_rvalid, 1'b0);
                    end
                    k++;
                end
                @(negedge clk);
                t++;
            end
            chk("txn_done", done, 1'b1);
        end
        drive_idle();
        #1;
        chk("back_idle", bus.busy, 1'b0);
    endtask

    initial begin
        logic [2:0] sz_tab [3];
        logic [2:0] sz;
        sz_tab[0] = 3'b001; sz_tab[1] = 3'b010; sz_tab[2] = 3'b100;

        drive_idle();
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_if_gnt", bus.if_gnt, 1'b0);
        chk("rst_ls_gnt", bus.ls_gnt, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", bus.mem_be, 4'h0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_rvalid", {bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);

        // Contention right after reset: LS first, then fetch.
        run_txn(1'b1, 1'b1, 32'h44, 32'h3000, 1'b0, 32'h0, 3'b100, 1, 2, 32'h12345678);
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 3'b000, 0, 0, 32'h0BADF00D);
        // Byte store to the top byte lane.
        run_txn(1'b0, 1'b1, 32'h0, 32'h1003, 1'b1, 32'hAB000000, 3'b001, 0, 1, 32'h0);
        // Misaligned half load.
        run_txn(1'b0, 1'b1, 32'h0, 32'h2001, 1'b0, 32'h0, 3'b010, 0, 0, 32'h0);
        // Misaligned word and non-one-hot size.
        run_txn(1'b0, 1'b1, 32'h0, 32'h2002, 1'b0, 32'h0, 3'b100, 0, 0, 32'h0);
        run_txn(1'b0, 1'b1, 32'h0, 32'h2000, 1'b0, 32'h0, 3'b110, 0, 0, 32'h0);
        // Fetch response.
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'b000, 0, 0, 32'hDEADBEEF);
        // Fetch never granted: timeout in REQ.
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'b000, -1, -1, 32'h0);
        // LS timeout in WAIT.
        run_txn(1'b0, 1'b1, 32'h0, 32'h500, 1'b0, 32'h0, 3'b100, 3, -1, 32'h0);
        // Response landing exactly on the timeout cycle wins.
        run_txn(1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 32'h0, 3'b000, 0, TMO - 1, 32'hCAFE0001);

        // Reset while a fetch is in WAIT; stale response afterwards is ignored.
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        #1;
        chk("mid_if_gnt", bus.if_gnt, 1'b1);
        @(negedge clk);
        bus.if_req  = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("mid_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        chk("mid_wait_busy", bus.busy, 1'b1);
        bus.ls_req = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_addr", bus.mem_addr, 32'h0);
        chk("mid_rst_be", bus.mem_be, 4'h0);
        chk("mid_rst_ls_gnt", bus.ls_gnt, 1'b0);
        chk("mid_rst_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.ls_req     = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        #1;
        chk("stale_if_rvalid", bus.if_rvalid, 1'b0);
        chk("stale_ls_rvalid", bus.ls_rvalid, 1'b0);
        chk("stale_busy", bus.busy, 1'b0);
        @(negedge clk);
        drive_idle();
        last_ls = 1'b0;

        // Last owner returns to fetch on reset, so LS wins the next contention.
        run_txn(1'b0, 1'b1, 32'h0, 32'h600, 1'b0, 32'h0, 3'b100, 0, 0, 32'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        last_ls = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 1'b1, 32'h700, 32'h604, 1'b1, 32'h5A5A5A5A, 3'b100, 1, 1, 32'h22);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) sz = 3'($urandom_range(0, 7));
            else                           sz = sz_tab[$urandom_range(0, 2)];
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom, sz,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
